mio_bus_ctrl: RTL and testbench
===============================

// Module: mio_bus_ctrl
// PURPOSE
//  Memory/IO bus slave directly downstream of the multi-cycle CPU controller.
//  Accepts single-word read/write requests (CPU_MIO + MemRead/MemWrite) and decodes the address into RAM, LED register or switch port.
//  Sequences the RAM access latency and returns MIO_ready plus read data; the controller's IF/memory states wait on MIO_ready.
// PARAMETERS
//  RAM_LATENCY  2   cycles between RAM address valid and ram_dout valid (1..7)
//  RAM_AW       10  RAM word-address width (RAM region = 4*2^RAM_AW bytes from 0x0)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   synchronous, active-high
//  CPU_MIO      in   1   bus request; requester holds it (and addr/op/data) stable until MIO_ready
//  MemRead      in   1   read operation
//  MemWrite     in   1   write operation
//  addr         in   32  byte address; bits[1:0] ignored
//  Data_out     in   32  CPU write data
//  Data_in      out  32  read data to CPU, valid when MIO_ready=1
//  MIO_ready    out  1   one-cycle completion pulse
//  bus_err      out  1   sticky error flag
//  ram_addr     out  RAM_AW  RAM word address (= latched addr[RAM_AW+1:2])
//  ram_din      out  32  RAM write data
//  ram_we       out  1   RAM write strobe, exactly one cycle per write
//  ram_dout     in   32  RAM read data
//  led          out  16  LED register
//  sw           in   16  switch inputs
// BEHAVIOUR
//  Reset (sync): state=IDLE; MIO_ready=0, Data_in=0, ram_we=0, led=0, bus_err=0, latches=0.
//  Regions (decode of latched addr): RAM addr < 4*2^RAM_AW; LED addr==0xE000_0000;
//    SW addr==0xF000_0000; anything else = UNMAPPED.
//  FSM: IDLE, RAM_WAIT, RESP.
//   IDLE: request accepted when CPU_MIO=1; latch addr, Data_out, op, region.
//     Next state RAM_WAIT (RAM read, wait counter loaded with RAM_LATENCY-1) else RESP.
//     SW read samples sw into read-data register at the accept edge.
//   RAM_WAIT: counter decrements each cycle; at 0 capture ram_dout, go RESP.
//   RESP: MIO_ready=1 for exactly this cycle; Data_in driven from capture register; -> IDLE.
//     RAM write: ram_we=1 in RESP only. LED write: led<=Data_out[15:0] at RESP edge.
//  Latency from accept edge N: RAM read ready at N+RAM_LATENCY+1; all others at N+1.
//  Data_in holds last read value until next read completes (writes leave it unchanged).
//  Error cases (complete normally with MIO_ready, Data_in=0 for reads, no side effect,
//    bus_err<=1): UNMAPPED address; MemRead=MemWrite=1; MemRead=MemWrite=0 with CPU_MIO;
//    write to SW; read of LED returns led value (legal, not an error).
//  CPU_MIO seen in RESP is ignored; a held request is re-accepted only in IDLE, so
//    back-to-back requests have one idle cycle minimum between pulses.
//  CPU_MIO dropping mid-access: access still completes (no abort); ready pulse still issued.
//  reset mid-access: immediate return to IDLE, no ram_we, no led update, no ready pulse.
//  ram_addr/ram_din driven continuously from latches (stable through RAM_WAIT/RESP).
// STRUCTURE
//  Shared package mio_pkg: region base constants (LED_ADDR, SW_ADDR), region enum
//    (RGN_RAM, RGN_LED, RGN_SW, RGN_NONE), FSM state encoding.
//  Sub-module mio_addr_decode: combinational addr -> region; instantiated once on
//    the live addr at accept time, result latched.
//  Top: FSM, wait counter ($clog2 width of RAM_LATENCY), data/addr latches, led register.
// TESTING
//  1 RAM_LATENCY=2: write 0xDEADBEEF @0x10 -> ram_we one cycle, ram_addr=4, MIO_ready at N+1;
//    then read @0x10 -> MIO_ready at N+3, Data_in=0xDEADBEEF.
//  2 Write 0x0001_A5A5 @0xE000_0000 -> led=0xA5A5 after ready; read it back -> Data_in=0x0000A5A5.
//  3 sw=0x1234, read @0xF000_0000 -> ready at N+1, Data_in=0x00001234; bus_err stays 0.
//  4 Read @0x8000_0000 -> ready, Data_in=0, bus_err=1 and stays 1; MemRead=MemWrite=1 same.
//  5 Hold CPU_MIO across two reads -> ready pulses separated by >=1 idle cycle, never 2 consecutive.
//  6 reset asserted during RAM_WAIT -> no MIO_ready, outputs at reset values next cycle,
//    new request after reset completes normally.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus slave: region map, region codes and FSM states.
package mio_pkg;

    localparam logic [31:0] LED_ADDR = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR  = 32'hF000_0000;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_LED,
        RGN_SW,
        RGN_NONE
    } region_e;

    typedef enum logic [1:0] {
        StIdle,
        StRamWait,
        StResp
    } state_e;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational byte-address to region decode; the two low address bits do not take part.
module mio_addr_decode
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW = 10
) (
    input  logic [31:0] addr,
    output region_e     region
);

    logic unused_lsb;
    assign unused_lsb = ^addr[1:0];

    always_comb begin
        region = RGN_NONE;
        if (addr[31:RAM_AW+2] == '0) begin
            region = RGN_RAM;
        end else if (addr[31:2] == LED_ADDR[31:2]) begin
            region = RGN_LED;
        end else if (addr[31:2] == SW_ADDR[31:2]) begin
            region = RGN_SW;
        end
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus slave: latches one CPU request, sequences RAM latency or LED/switch access,
// and answers with a single-cycle MIO_ready pulse.
module mio_bus_ctrl
    import mio_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned RAM_AW      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    output logic [15:0]       led,
    input  logic [15:0]       sw
);

    localparam int unsigned    CntW    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(RAM_LATENCY - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [31:0]       wdata_q;
    region_e           region_q;
    logic              wr_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [15:0]       led_q;
    logic              bus_err_q;

    region_e dec_region;
    logic    req_wr, req_rd, req_err, req_ram_rd;
    logic    accept, capture_ram, resp_active;

    mio_addr_decode #(
        .RAM_AW (RAM_AW)
    ) u_addr_decode (
        .addr   (addr),
        .region (dec_region)
    );

    // Classify the live request; only meaningful on the accept cycle.
    always_comb begin
        req_rd     = MemRead & ~MemWrite;
        req_wr     = MemWrite & ~MemRead;
        req_err    = (dec_region == RGN_NONE) || (MemRead == MemWrite) ||
                     (req_wr && (dec_region == RGN_SW));
        req_ram_rd = req_rd && (dec_region == RGN_RAM);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        capture_ram = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (CPU_MIO) begin
                    accept = 1'b1;
                    if (req_ram_rd) begin
                        state_d = StRamWait;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StRamWait: begin
                if (cnt_q == '0) begin
                    capture_ram = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            region_q   <= RGN_RAM;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            led_q      <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ram_addr_q <= addr[RAM_AW+1:2];
                wdata_q    <= Data_out;
                region_q   <= dec_region;
                wr_q       <= req_wr;
                err_q      <= req_err;
                if (req_err) begin
                    bus_err_q <= 1'b1;
                end
                // Any read-type request refreshes Data_in; failed reads return zero.
                if (MemRead) begin
                    if (req_err) begin
                        rdata_q <= '0;
                    end else if (dec_region == RGN_SW) begin
                        rdata_q <= {16'h0000, sw};
                    end else if (dec_region == RGN_LED) begin
                        rdata_q <= {16'h0000, led_q};
                    end
                end
            end
            if (capture_ram) begin
                rdata_q <= ram_dout;
            end
            if ((state_q == StResp) && wr_q && !err_q && (region_q == RGN_LED)) begin
                led_q <= wdata_q[15:0];
            end
        end
    end

    // Reset suppresses the response cycle immediately, not one cycle later.
    assign resp_active = (state_q == StResp) && !reset;

    assign MIO_ready = resp_active;
    assign ram_we    = resp_active && wr_q && !err_q && (region_q == RGN_RAM);
    assign Data_in   = rdata_q;
    assign bus_err   = bus_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = wdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Scoreboard bench for mio_bus_ctrl: driver pushes model predictions, monitor checks on MIO_ready.
module tb_mio_bus_ctrl;

    localparam int RAM_LATENCY = 2;
    localparam int RAM_AW      = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              CPU_MIO;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       addr;
    logic [31:0]       Data_out;
    logic [31:0]       Data_in;
    logic              MIO_ready;
    logic              bus_err;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;
    logic [15:0]       led;
    logic [15:0]       sw;

    mio_bus_ctrl #(
        .RAM_LATENCY (RAM_LATENCY),
        .RAM_AW      (RAM_AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (CPU_MIO),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .Data_out  (Data_out),
        .Data_in   (Data_in),
        .MIO_ready (MIO_ready),
        .bus_err   (bus_err),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .led       (led),
        .sw        (sw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment RAM: one register stage, so data sampled RAM_LATENCY edges after the address.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state.
    typedef struct {
        int          cyc;
        bit          ram_rd;
        logic [31:0] data;
        logic        err;
        logic        we;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [15:0] led;
    } exp_t;

    logic [31:0] ref_mem [int unsigned];
    logic [15:0] ref_led  = '0;
    logic        ref_err  = 1'b0;
    logic [31:0] ref_last = '0;
    exp_t        sb [$];

    function automatic exp_t model(input bit rd, input bit wr, input logic [31:0] a,
                                   input logic [31:0] d, input logic [15:0] s);
        exp_t        e;
        logic [31:0] aw;
        bit          is_ram, is_led, is_sw, err;
        aw     = a & 32'hFFFF_FFFC;
        is_ram = a < 32'd4096;
        is_led = aw == 32'hE000_0000;
        is_sw  = aw == 32'hF000_0000;
        err    = (rd == wr) || !(is_ram || is_led || is_sw) || (wr && !rd && is_sw);
        if (err) ref_err = 1'b1;
        if (rd) begin
            if (err)         ref_last = 32'h0;
            else if (is_ram) ref_last = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
            else if (is_led) ref_last = {16'h0, ref_led};
            else             ref_last = {16'h0, s};
        end
        e.we = !err && wr && is_ram;
        if (e.we) ref_mem[a >> 2] = d;
        if (!err && wr && is_led) ref_led = d[15:0];
        e.cyc    = 0;
        e.ram_rd = rd && !wr && is_ram;
        e.data   = ref_last;
        e.err    = ref_err;
        e.waddr  = a[11:2];
        e.wdata  = d;
        e.led    = ref_led;
        return e;
    endfunction

    // Monitor.
    exp_t        mon_e;
    bit          prev_ready = 1'b0;
    bit          led_pend   = 1'b0;
    logic [15:0] led_exp;

    always @(negedge clk) begin
        if (led_pend) begin
            led_pend = 1'b0;
            chk("led_after_resp", {16'h0, led}, {16'h0, led_exp});
        end
        if (ram_we) chk("ram_we_outside_resp", {31'h0, MIO_ready}, 32'h1);
        if (MIO_ready) begin
            chk("ready_back_to_back", {31'h0, prev_ready}, 32'h0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got ready at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("ready_cycle", cyc, mon_e.cyc);
                chk("data_in", Data_in, mon_e.data);
                chk("bus_err", {31'h0, bus_err}, {31'h0, mon_e.err});
                chk("ram_we", {31'h0, ram_we}, {31'h0, mon_e.we});
                if (mon_e.we) begin
                    chk("ram_addr", {22'h0, ram_addr}, {22'h0, mon_e.waddr});
                    chk("ram_din", ram_din, mon_e.wdata);
                end
                led_exp  = mon_e.led;
                led_pend = 1'b1;
            end
        end
        prev_ready = MIO_ready;
    end

    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!MIO_ready && n < 20);
        if (!MIO_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no ready in %0d cycles, expected ready", name, n);
        end
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [15:0] s);
        exp_t e;
        @(negedge clk);
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        Data_out = d;
        sw       = s;
        CPU_MIO  = 1'b1;
        e        = model(rd, wr, a, d, s);
        e.cyc    = cyc + 1 + (e.ram_rd ? RAM_LATENCY : 0);
        sb.push_back(e);
        wait_ready("issue");
        CPU_MIO = 1'b0;
    endtask

    // CPU_MIO held high across two identical reads.
    task automatic hold2(input logic [31:0] a);
        exp_t e1, e2;
        @(negedge clk);
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        addr     = a;
        CPU_MIO  = 1'b1;
        e1       = model(1'b1, 1'b0, a, Data_out, sw);
        e1.cyc   = cyc + 1 + (e1.ram_rd ? RAM_LATENCY : 0);
        e2       = model(1'b1, 1'b0, a, Data_out, sw);
        e2.cyc   = e1.cyc + 2 + (e2.ram_rd ? RAM_LATENCY : 0);
        sb.push_back(e1);
        sb.push_back(e2);
        wait_ready("hold_first");
        wait_ready("hold_second");
        CPU_MIO = 1'b0;
    endtask

    logic [31:0] ra;
    int          k;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset    = 1'b1;
        CPU_MIO  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = '0;
        Data_out = '0;
        sw       = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, MIO_ready}, 32'h0);
        chk("rst_data_in", Data_in, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);

        issue(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0);
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 16'h0);
        issue(1'b0, 1'b1, 32'hE000_0000, 32'h0001_A5A5, 16'h0);
        issue(1'b1, 1'b0, 32'hE000_0000, 32'h0, 16'h0);
        issue(1'b1, 1'b0, 32'hF000_0000, 32'h0, 16'h1234);
        issue(1'b0, 1'b1, 32'h0000_0FFC, 32'h1357_9BDF, 16'h0);
        issue(1'b1, 1'b0, 32'h0000_0FFF, 32'h0, 16'h0);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h0, 16'h0);
        issue(1'b1, 1'b1, 32'h0000_0010, 32'h0, 16'h0);
        issue(1'b0, 1'b0, 32'h0000_0010, 32'h0, 16'h0);
        issue(1'b0, 1'b1, 32'hF000_0000, 32'h5555_5555, 16'h0);
        issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 16'h0);
        hold2(32'h0000_0010);
        hold2(32'hF000_0000);

        // Reset during RAM_WAIT: the access must vanish without a ready pulse.
        @(negedge clk);
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        addr     = 32'h0000_0010;
        CPU_MIO  = 1'b1;
        @(negedge clk);
        reset   = 1'b1;
        CPU_MIO = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", {31'h0, MIO_ready}, 32'h0);
        chk("midrst_data_in", Data_in, 32'h0);
        chk("midrst_led", {16'h0, led}, 32'h0);
        chk("midrst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("midrst_ram_we", {31'h0, ram_we}, 32'h0);
        ref_led  = '0;
        ref_err  = 1'b0;
        ref_last = '0;
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 16'h0);

        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 9);
            ra = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            case (k)
                0, 1: issue(1'b0, 1'b1, ra, $urandom, 16'($urandom));
                2, 3: issue(1'b1, 1'b0, ra, $urandom, 16'($urandom));
                4:    issue(1'b0, 1'b1, 32'hE000_0000 | 32'($urandom_range(0, 3)), $urandom,
                            16'($urandom));
                5:    issue(1'b1, 1'b0, 32'hE000_0000, $urandom, 16'($urandom));
                6:    issue(1'b1, 1'b0, 32'hF000_0000 | 32'($urandom_range(0, 3)), $urandom,
                            16'($urandom));
                7:    issue(1'b0, 1'b1, 32'hF000_0000, $urandom, 16'($urandom));
                8:    issue(1'($urandom), 1'b0, 32'h0000_1000 + 32'($urandom_range(0, 4000)),
                            $urandom, 16'($urandom));
                default: begin
                    if ($urandom_range(0, 1) == 1) issue(1'b1, 1'b1, ra, $urandom, 16'($urandom));
                    else                           issue(1'b0, 1'b0, ra, $urandom, 16'($urandom));
                end
            endcase
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
